// File: rtl/obi_mem_secondary.sv
// ============================================================================
// Module   : obi_mem_secondary
// Purpose  : OBI responder on one clock, backed by word-addressed memory.
//            Returns in-order responses after a fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_mem_secondary #(
  parameter int WORDS           = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int c_aw = $clog2(WORDS);
  localparam int c_cw = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cw-1:0] c_max = c_cw'(MAX_OUTSTANDING);

  logic [31:0]              r_mem [WORDS];
  logic [c_cw-1:0]          r_cnt;
  logic [LATENCY-1:0]       r_vld;
  logic [LATENCY-1:0]       r_err;
  logic [LATENCY-1:0][31:0] r_dat;

  logic [c_aw-1:0] w_idx;
  logic [31:0]     w_hi;
  logic            w_in_range;
  logic            w_accept;

  assign w_idx      = addr_i[c_aw+1:2];
  assign w_hi       = addr_i >> (c_aw + 2);
  assign w_in_range = (w_hi == 32'd0);

  // A slot retiring this cycle can be handed to a new request immediately.
  assign gnt_o    = req_i && !rst_i && ((r_cnt < c_max) || rvalid_o);
  assign w_accept = req_i && gnt_o;

  assign rvalid_o = r_vld[LATENCY-1] && !rst_i;
  assign err_o    = rvalid_o && r_err[LATENCY-1];
  assign rdata_o  = rvalid_o ? r_dat[LATENCY-1] : 32'd0;

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && we_i && w_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      case ({w_accept, rvalid_o})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload only matters while its valid bit is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    r_err[0] <= !w_in_range;
    r_dat[0] <= (!we_i && w_in_range) ? r_mem[w_idx] : 32'd0;
    for (int i = 1; i < LATENCY; i++) begin
      r_err[i] <= r_err[i-1];
      r_dat[i] <= r_dat[i-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_secondary.sv
// ============================================================================
// Module   : tb_obi_mem_secondary
// Purpose  : Three differently configured responders checked against a
//            queue-based transaction model with directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_mem_secondary;

  localparam int N = 3;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
    logic [31:0] mask;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [N];
  logic        we     [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic [3:0]  be     [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic        err    [N];
  logic [31:0] rdata  [N];

  int latv [N] = '{1, 3, 4};
  int maxv [N] = '{2, 1, 3};

  rsp_t        q  [N][$];
  logic [31:0] mm [N][1024];
  logic [31:0] kn [N][1024];
  bit          acc [N];
  int          cyc, nchk, nerr;

  always #5 clk = ~clk;

  obi_mem_secondary #(.WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  obi_mem_secondary #(.WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  obi_mem_secondary #(.WORDS(1024), .LATENCY(4), .MAX_OUTSTANDING(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic offer(input int i, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; be[i] = 4'd0; wdata[i] = 32'd0;
    end
  endtask

  // Transaction-level effect of one grant: memory update plus a response due later.
  task automatic model_accept(input int i);
    rsp_t        r;
    logic [31:0] a;
    int          w;
    a      = addr[i];
    w      = int'(a[11:2]);
    r.due  = cyc + latv[i];
    r.err  = 1'b0;
    r.data = 32'd0;
    r.mask = 32'hFFFF_FFFF;
    if ((a >> 12) != 32'd0) begin
      r.err = 1'b1;
    end else if (we[i]) begin
      for (int k = 0; k < 4; k++) begin
        if (be[i][k]) begin
          mm[i][w][8*k +: 8] = wdata[i][8*k +: 8];
          kn[i][w][8*k +: 8] = 8'hFF;
        end
      end
    end else begin
      r.data = mm[i][w];
      r.mask = kn[i][w];
    end
    q[i].push_back(r);
  endtask

  task automatic tick();
    #1;
    for (int i = 0; i < N; i++) begin
      int   sz;
      bit   ret;
      bit   g;
      rsp_t h;
      sz  = q[i].size();
      ret = (sz > 0) && (q[i][0].due == cyc);
      chk("rvalid", i, 32'(rvalid[i]), 32'(ret && !rst));
      if (ret) begin
        h = q[i].pop_front();
        if (!rst) begin
          chk("err", i, 32'(err[i]), 32'(h.err));
          chk("rdata", i, rdata[i] & h.mask, h.data & h.mask);
        end
      end
      if (rst) begin
        chk("rst_rdata", i, rdata[i], 32'd0);
        chk("rst_err", i, 32'(err[i]), 32'd0);
      end
      g = req[i] && !rst && ((sz < maxv[i]) || ret);
      chk("gnt", i, 32'(gnt[i]), 32'(g));
      acc[i] = g;
      if (rst) q[i].delete();
      else if (g) model_accept(i);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
    else a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    nchk = 0; nerr = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin
      acc[i] = 1'b0;
      for (int w = 0; w < 1024; w++) begin
        mm[i][w] = 32'd0;
        kn[i][w] = 32'd0;
      end
    end
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Reset held with requests pending
    for (int i = 0; i < N; i++) offer(i, 1'b0, 32'h10, 4'hF, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    idle();
    tick();

    // Write then read-after-write on the next cycle
    offer(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF); tick();
    offer(0, 1'b0, 32'h10, 4'h0, 32'd0);         tick();
    idle(); repeat (2) tick();

    // Byte enables over an existing word
    offer(0, 1'b1, 32'h20, 4'hF, 32'hAAAA_AAAA); tick();
    offer(0, 1'b1, 32'h20, 4'h5, 32'h1122_3344); tick();
    offer(0, 1'b0, 32'h20, 4'hF, 32'd0);         tick();
    idle(); repeat (2) tick();

    // Backpressure with one outstanding slot and latency 3
    offer(1, 1'b1, 32'h30, 4'hF, 32'h1234_5678); tick();
    idle(); repeat (4) tick();
    offer(1, 1'b0, 32'h30, 4'h0, 32'd0);
    repeat (6) tick();
    idle(); repeat (4) tick();

    // Out-of-range accesses leave word 0 untouched
    offer(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D);         tick();
    offer(0, 1'b0, 32'h0000_1000, 4'hF, 32'd0);         tick();
    offer(0, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF); tick();
    offer(0, 1'b0, 32'h0, 4'h0, 32'd0);                 tick();
    idle(); repeat (2) tick();

    // Reset while three reads are in flight
    offer(2, 1'b1, 32'h40, 4'hF, 32'hCAFE_0042); tick();
    idle(); repeat (5) tick();
    offer(2, 1'b0, 32'h40, 4'h0, 32'd0);
    repeat (3) tick();
    idle(); tick();
    rst = 1'b1; repeat (2) tick();
    rst = 1'b0; repeat (6) tick();
    offer(2, 1'b0, 32'h40, 4'h0, 32'd0); tick();
    idle(); repeat (5) tick();

    // Random traffic with held requests and occasional resets
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || acc[i]) begin
          if ($urandom_range(0, 3) != 0)
            offer(i, 1'($urandom_range(0, 1)), rnd_addr(), 4'($urandom), $urandom);
          else
            req[i] = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
